// File: rtl/seq_alu_flagged.sv
// Execute stage feeding the processor flags register: single-cycle ALU ops plus
// an iterative LSB-first shift-add multiply, with merged 5-bit flags {C,L,F,Z,N}.
module seq_alu_flagged #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       flags_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             rd_we,
   output logic [4:0]       flags,
   output logic             flag_en
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_CMP = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_MOV = 4'd6;
   localparam logic [3:0] OP_LSH = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   localparam int FC = 4;
   localparam int FL = 3;
   localparam int FF = 2;
   localparam int FZ = 1;
   localparam int FN = 0;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [SHW+1:0] WIDTH_M = (SHW+2)'(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t               state;
   logic [CW-1:0]        cnt_p0;
   logic [2*WIDTH-1:0]   prod_p0;
   logic [WIDTH-1:0]     mcand_p0;
   logic [4:0]           flg_p0;

   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;
   logic [WIDTH:0]       sum_w;
   logic [WIDTH:0]       dif_w;
   logic [WIDTH-1:0]     alu_res;
   logic [4:0]           alu_flg;
   logic                 alu_we;
   logic                 alu_fen;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;

   // Two's-complement shift amount: positive shifts left, negative shifts right;
   // any magnitude of WIDTH or more flushes the value to zero.
   function automatic logic [WIDTH-1:0] lsh(input logic [WIDTH-1:0] v,
                                            input logic signed [SHW:0] k);
      logic [SHW+1:0] mag;
      logic [WIDTH-1:0] r;
      if (k >= 0) mag = {1'b0, k};
      else        mag = -{k[SHW], k};
      if (mag >= WIDTH_M)  r = '0;
      else if (k >= 0)     r = v << mag;
      else                 r = v >> mag;
      return r;
   endfunction

   assign a_s   = a;
   assign b_s   = b;
   assign sum_w = {1'b0, a} + {1'b0, b};
   assign dif_w = {1'b0, a} - {1'b0, b};
   assign busy  = (state != S_IDLE);

   always_comb begin
      alu_res = result;
      alu_flg = flags_in;
      alu_we  = 1'b0;
      alu_fen = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res     = sum_w[WIDTH-1:0];
            alu_flg[FC] = sum_w[WIDTH];
            alu_flg[FF] = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            alu_flg[FZ] = ~|sum_w[WIDTH-1:0];
            alu_flg[FN] = sum_w[WIDTH-1];
            alu_we      = 1'b1;
            alu_fen     = 1'b1;
         end
         OP_SUB: begin
            alu_res     = dif_w[WIDTH-1:0];
            alu_flg[FC] = dif_w[WIDTH];
            alu_flg[FF] = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
            alu_flg[FZ] = ~|dif_w[WIDTH-1:0];
            alu_flg[FN] = dif_w[WIDTH-1];
            alu_we      = 1'b1;
            alu_fen     = 1'b1;
         end
         OP_CMP: begin
            alu_flg[FL] = (a < b);
            alu_flg[FN] = (a_s < b_s);
            alu_flg[FZ] = (a == b);
            alu_fen     = 1'b1;
         end
         OP_AND: begin alu_res = a & b; alu_we = 1'b1; end
         OP_OR:  begin alu_res = a | b; alu_we = 1'b1; end
         OP_XOR: begin alu_res = a ^ b; alu_we = 1'b1; end
         OP_MOV: begin alu_res = b;     alu_we = 1'b1; end
         OP_LSH: begin
            alu_res = lsh(a, $signed(b[SHW:0]));
            alu_we  = 1'b1;
         end
         default: ;
      endcase
   end

   // One shift-add step: conditionally add the multiplicand into the high half,
   // then shift the whole product right, consuming one multiplier bit.
   assign mul_sum  = {1'b0, prod_p0[2*WIDTH-1:WIDTH]} +
                     (prod_p0[0] ? {1'b0, mcand_p0} : '0);
   assign mul_next = {mul_sum, prod_p0[WIDTH-1:1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         done     <= 1'b0;
         rd_we    <= 1'b0;
         flag_en  <= 1'b0;
         result   <= '0;
         flags    <= '0;
         cnt_p0   <= '0;
         prod_p0  <= '0;
         mcand_p0 <= '0;
         flg_p0   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mcand_p0 <= a;
                  flg_p0   <= flags_in;
                  if (op == OP_MUL) begin
                     prod_p0 <= {{WIDTH{1'b0}}, b};
                     cnt_p0  <= CW'(WIDTH);
                     state   <= S_MUL;
                  end else begin
                     result  <= alu_res;
                     flags   <= alu_flg;
                     rd_we   <= alu_we;
                     flag_en <= alu_fen;
                     done    <= 1'b1;
                     state   <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               prod_p0 <= mul_next;
               cnt_p0  <= cnt_p0 - CW'(1);
               if (cnt_p0 == CW'(1)) begin
                  result  <= mul_next[WIDTH-1:0];
                  flags   <= {|mul_next[2*WIDTH-1:WIDTH], flg_p0[FL], flg_p0[FF],
                              ~|mul_next[WIDTH-1:0], mul_next[WIDTH-1]};
                  rd_we   <= 1'b1;
                  flag_en <= 1'b1;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               rd_we   <= 1'b0;
               flag_en <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu_flagged.sv
// Bench for seq_alu_flagged: directed cases plus randomized ops checked against
// an arithmetic reference model of the opcode rules.
module tb_seq_alu_flagged;

   localparam int W = 16;

   logic          clk, reset, start;
   logic [3:0]    op;
   logic [W-1:0]  a, b, result;
   logic [4:0]    flags_in, flags;
   logic          busy, done, rd_we, flag_en;

   int            n_run = 0;
   int            n_fail = 0;
   logic [15:0]   prev_res;

   typedef struct packed {
      logic [15:0] res;
      logic [4:0]  flg;
      logic        we;
      logic        fen;
   } exp_t;

   seq_alu_flagged #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .flags_in(flags_in), .busy(busy), .done(done), .result(result),
      .rd_we(rd_we), .flags(flags), .flag_en(flag_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int sx(input int v);
      return (v >= 32768) ? v - 65536 : v;
   endfunction

   function automatic exp_t model(input int o, input int x, input int y,
                                  input logic [4:0] fi, input logic [15:0] prev);
      exp_t e;
      int r, s, k;
      longint p;
      bit c, l, f, z, n, zn;
      {c, l, f, z, n} = fi;
      r = int'(prev);
      zn = 0;
      e.we = 0;
      e.fen = 0;
      case (o)
         0: begin
            r = (x + y) % 65536; c = (x + y) > 65535;
            s = sx(x) + sx(y); f = (s > 32767) || (s < -32768);
            zn = 1; e.we = 1; e.fen = 1;
         end
         1: begin
            r = (x - y + 65536) % 65536; c = x < y;
            s = sx(x) - sx(y); f = (s > 32767) || (s < -32768);
            zn = 1; e.we = 1; e.fen = 1;
         end
         2: begin l = x < y; n = sx(x) < sx(y); z = (x == y); e.fen = 1; end
         3: begin r = x & y; e.we = 1; end
         4: begin r = x | y; e.we = 1; end
         5: begin r = x ^ y; e.we = 1; end
         6: begin r = y;     e.we = 1; end
         7: begin
            k = y % 32;
            if (k >= 16) k = k - 32;
            if (k >= 0)        r = (x << k) % 65536;
            else if (-k >= 16) r = 0;
            else               r = x >> (-k);
            e.we = 1;
         end
         8: begin
            p = longint'(x) * longint'(y);
            r = int'(p % 65536); c = (p / 65536) != 0;
            zn = 1; e.we = 1; e.fen = 1;
         end
         default: ;
      endcase
      if (zn) begin z = (r == 0); n = (r >= 32768); end
      e.res = 16'(r);
      e.flg = {c, l, f, z, n};
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_run++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic run_op(input logic [3:0] o, input logic [15:0] ai, input logic [15:0] bi,
                         input logic [4:0] fi, input bit noisy);
      exp_t e;
      int n, lat;
      e = model(int'(o), int'(ai), int'(bi), fi, prev_res);
      lat = (o == 4'd8) ? W + 1 : 1;
      op = o; a = ai; b = bi; flags_in = fi; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      do begin
         if (noisy) begin
            start = 1'($urandom_range(0, 1));
            op = 4'($urandom); a = W'($urandom); b = W'($urandom); flags_in = 5'($urandom);
         end
         @(negedge clk);
         n++;
         if (n == 1 && o == 4'd8) begin
            chk("mul_busy", busy, 1);
            chk("mul_no_early_done", done, 0);
         end
      end while (!done && n < 40);
      start = 1'b0;
      chk("latency", n, lat);
      chk("result", result, e.res);
      chk("flags", flags, e.flg);
      chk("rd_we", rd_we, e.we);
      chk("flag_en", flag_en, e.fen);
      prev_res = e.res;
      @(negedge clk);
      chk("done_clear", done, 0);
      chk("rd_we_clear", rd_we, 0);
      chk("flag_en_clear", flag_en, 0);
      chk("busy_clear", busy, 0);
   endtask

   initial begin
      exp_t e;
      bit seen;
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flags_in = '0;
      prev_res = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", flags, 0);
      chk("rst_rd_we", rd_we, 0);
      chk("rst_flag_en", flag_en, 0);
      reset = 1'b0;
      @(negedge clk);

      run_op(4'd0, 16'h7FFF, 16'h0001, 5'b00000, 0);
      chk("plan_add_res", result, 16'h8000);
      chk("plan_add_flg", flags, 5'b00101);
      run_op(4'd1, 16'h0000, 16'h0001, 5'b00000, 0);
      chk("plan_sub_res", result, 16'hFFFF);
      chk("plan_sub_flg", flags, 5'b10001);
      run_op(4'd2, 16'h0003, 16'hFFFB, 5'b00000, 0);
      chk("plan_cmp_res", result, 16'hFFFF);
      chk("plan_cmp_flg", flags, 5'b01000);
      run_op(4'd8, 16'h0100, 16'h0100, 5'b00000, 1);
      chk("plan_mul_res", result, 16'h0000);
      chk("plan_mul_flg", flags, 5'b10010);
      run_op(4'd3, 16'hF0F0, 16'h0FF0, 5'b10101, 0);
      chk("plan_and_res", result, 16'h00F0);
      chk("plan_and_flg", flags, 5'b10101);
      run_op(4'd7, 16'h8001, 16'hFFFF, 5'b00000, 0);
      chk("plan_lsh_r1", result, 16'h4000);
      run_op(4'd7, 16'h8001, 16'h0004, 5'b00000, 0);
      chk("plan_lsh_l4", result, 16'h0010);
      run_op(4'd7, 16'hFFFF, 16'h0010, 5'b00000, 0);
      chk("lsh_r16_zero", result, 16'h0000);
      run_op(4'd7, 16'h0001, 16'h000F, 5'b00000, 0);
      chk("lsh_l15", result, 16'h8000);
      run_op(4'd2, 16'h1234, 16'h1234, 5'b10100, 0);
      run_op(4'd12, 16'h1111, 16'h2222, 5'b01010, 1);
      run_op(4'd8, 16'hFFFF, 16'hFFFF, 5'b01100, 1);

      // Asynchronous reset in the middle of a multiply.
      op = 4'd8; a = 16'h0100; b = 16'h0100; flags_in = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_mul_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_result", result, 0);
      chk("arst_flags", flags, 0);
      chk("arst_rd_we", rd_we, 0);
      chk("arst_flag_en", flag_en, 0);
      @(negedge clk);
      reset = 1'b0;
      prev_res = '0;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk("arst_no_done", seen, 0);
      run_op(4'd0, 16'h1234, 16'h4321, 5'b00000, 0);

      // Start held high with ADDs: accepts every other edge.
      e = '0;
      for (int i = 0; i < 20; i++) begin
         op = 4'd0; a = W'($urandom); b = W'($urandom); flags_in = 5'($urandom);
         start = 1'b1;
         if (i % 2 == 0) e = model(0, int'(a), int'(b), flags_in, prev_res);
         @(posedge clk);
         @(negedge clk);
         chk("b2b_done", done, (i % 2 == 0) ? 1 : 0);
         if (i % 2 == 0) begin
            chk("b2b_result", result, e.res);
            chk("b2b_flags", flags, e.flg);
            prev_res = e.res;
         end
      end
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("b2b_idle", busy, 0);

      for (int i = 0; i < 60; i++) begin
         logic [3:0] ro;
         ro = (i % 5 == 0) ? 4'd8 : 4'($urandom);
         run_op(ro, 16'($urandom), 16'($urandom), 5'($urandom), 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_alu_flagged.md
Name: seq_alu_flagged

Overview:
- Upstream execute stage that feeds the processor flags register (loads 5-bit flags on a one-cycle enable).
- Accepts one operation per start handshake: single-cycle ALU ops, plus an iterative shift-add multiply.
- Returns result, done and write-enable, a full 5-bit flags word and a flag-load enable.
- The flags word has unaffected bits merged from the current flags register value.

Parameters:
- WIDTH, 16, datapath width in bits (>= 4).
- SHW, $clog2(WIDTH), shift-amount field width minus one.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- start  in  1  request; sampled only when busy=0
- op  in  4  opcode: 0 ADD, 1 SUB, 2 CMP, 3 AND, 4 OR, 5 XOR, 6 MOV, 7 LSH, 8 MUL, 9-15 NOP
- a  in  WIDTH  operand A (Rdest)
- b  in  WIDTH  operand B (Rsrc/immediate)
- flags_in  in  5  current flags register contents
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse: result, flags, rd_we valid
- result  out  WIDTH  operation result, held until next done
- rd_we  out  1  pulses with done when result must be written back
- flags  out  5  {C, L, F, Z, N} = bits [4:0]
- flag_en  out  1  pulses with done when the op affects any flag

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, rd_we, flag_en = 0; result = 0; flags = 0; any multiply in progress is abandoned.
- States are IDLE, MUL, and DONE.
- IDLE: on posedge with start=1, latch op, a, b and flags_in.
  - op 8: go to MUL, load counter=WIDTH and accumulator=0.
  - Else: compute and go to DONE.
- MUL: one shift-add step per cycle (multiplier LSB-first). The counter decrements. When it reaches 0, go to DONE. Takes exactly WIDTH cycles.
- DONE: done=1 for exactly one cycle. rd_we and flag_en qualify that same cycle. Then go to IDLE.
- start is ignored while busy=1, including the DONE cycle. The earliest new accept is the cycle after done.
- Latency, counting the start edge as cycle 0:
  - Single-cycle ops: done is visible in cycle 1.
  - MUL: done is visible in cycle WIDTH+1.
- done, rd_we and flag_en are 0 in all states other than DONE.
- Flags: bits not listed for an op are copied from the latched flags_in.
  - Z = result==0.
  - N = result MSB, except for CMP.
- ADD: result = a+b mod 2^WIDTH.
  - C = carry out.
  - F = signed overflow (operand signs equal, result sign differs).
  - Updates C, F, Z, N. rd_we=1, flag_en=1.
- SUB: result = a-b.
  - C = borrow (a<b unsigned).
  - F = signed overflow (operand signs differ, result sign differs from a).
  - Updates C, F, Z, N. rd_we=1, flag_en=1.
- CMP: no writeback, rd_we=0, result holds its previous value.
  - L = a<b unsigned.
  - N = a<b signed.
  - Z = a==b.
  - Updates L, N, Z. flag_en=1.
- AND, OR, XOR, MOV (result=b): rd_we=1, flag_en=0, flags = latched flags_in.
- LSH: amount k = b[SHW:0] as two's complement.
  - k >= 0: logical left shift by k.
  - k < 0: logical right shift by -k. A shift of >= WIDTH gives 0.
  - rd_we=1, flag_en=0.
- MUL: result = low WIDTH bits of the unsigned 2*WIDTH product.
  - C = high half nonzero.
  - Updates C, Z, N. rd_we=1, flag_en=1.
- NOP (9-15): done pulses, rd_we=0, flag_en=0.
- Operand or flags_in changes after accept have no effect on the operation in flight.

Test Plan:
- ADD a=0x7FFF b=0x0001 flags_in=0 -> cycle 1: done=1, result=0x8000, flags=5'b00101 (F=1, N=1), flag_en=1, rd_we=1; cycle 2: all pulses 0.
- SUB a=0x0000 b=0x0001 -> result=0xFFFF, C=1, N=1, Z=0, F=0; CMP a=0x0003 b=0xFFFB -> L=1, N=0, Z=0, rd_we=0, result unchanged.
- MUL a=0x0100 b=0x0100 -> busy for 16 cycles, done at cycle 17, result=0x0000, C=1, Z=1, N=0; toggling start/a/b mid-multiply has no effect.
- AND a=0xF0F0 b=0x0FF0 flags_in=5'b10101 -> result=0x00F0, flags=5'b10101, flag_en=0; LSH a=0x8001 b=0xFFFF -> 0x4000, b=0x0004 -> 0x0010.
- Assert reset asynchronously at cycle 5 of MUL -> outputs 0 immediately; no done; new ADD accepted after reset release completes normally.
- Back-to-back: start held high continuously with ADDs -> accepts on cycles 0, 2, 4, ... with one done per accepted op, none dropped or duplicated.
